// File: rtl/hs_pkg.sv
// Shared types and constants for the four-phase req/ack crossing.
// Used by the transmitter and the matching receiver.
package hs_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RELEASE
  } hs_state_t;

  localparam int HS_DEFAULT_WIDTH = 4;
  localparam int HS_MIN_SYNC      = 2;

endpackage

// File: rtl/handshake_tx_sync_stages.sv
// N-flop single-bit synchroniser with async active-low reset.
// Shared by both ends of the req/ack crossing.
module sync_stages
  import hs_pkg::*;
#(
  parameter int N = HS_MIN_SYNC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] sync_q;

  if (N < HS_MIN_SYNC) begin : g_bad_n
    $error("sync_stages: N must be at least HS_MIN_SYNC");
  end

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[N-2:0], d_i};
    end
  end

  assign q_o = sync_q[N-1];

endmodule

// File: rtl/handshake_tx.sv
// Transmit side of a four-phase req/ack crossing.
// Holds a captured word while req is raised to the remote domain.
module handshake_tx
  import hs_pkg::*;
#(
  parameter int WIDTH       = HS_DEFAULT_WIDTH,
  parameter int SYNC_STAGES = HS_MIN_SYNC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             tx_req,
  output logic [WIDTH-1:0] tx_data,
  input  logic             tx_ack,
  output logic             done,
  output logic             busy
);

  hs_state_t        state_q;
  logic             req_q;
  logic [WIDTH-1:0] data_q;
  logic             done_q;
  logic             ack_s;
  logic             accept;

  sync_stages #(
    .N (SYNC_STAGES)
  ) u_ack_sync (
    .clk   (clk),
    .rst_n (reset),
    .d_i   (tx_ack),
    .q_o   (ack_s)
  );

  assign accept = (state_q == IDLE) && in_valid;

  // Handshake FSM; req is a flop output so it cannot glitch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_q <= REQ;
            req_q   <= 1'b1;
          end
        end
        REQ: begin
          if (ack_s) begin
            state_q <= RELEASE;
            req_q   <= 1'b0;
          end
        end
        RELEASE: begin
          if (!ack_s) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  // Word register loads only on an accepted handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
    end else if (accept) begin
      data_q <= in_data;
    end
  end

  // Completion pulse coincides with the return to IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == RELEASE) && !ack_s;
    end
  end

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign tx_req   = req_q;
  assign tx_data  = data_q;
  assign done     = done_q;

endmodule

// File: tb/tb_handshake_tx.sv
// Directed self-checking bench for handshake_tx.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_handshake_tx;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic       tx_req;
  logic [3:0] tx_data;
  logic       tx_ack;
  logic       done;
  logic       busy;

  int n_chk;
  int n_err;

  handshake_tx #(
    .WIDTH       (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .tx_req   (tx_req),
    .tx_data  (tx_data),
    .tx_ack   (tx_ack),
    .done     (done),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_req"},   tx_req,   0);
    chk({tag, "_rdy"},   in_ready, 1);
    chk({tag, "_busy"},  busy,     0);
    chk({tag, "_done"},  done,     0);
  endtask

  initial begin
    n_chk    = 0;
    n_err    = 0;
    reset    = 1'b0;
    tx_ack   = 1'b0;
    in_valid = 1'b0;
    in_data  = 4'h0;

    // reset state
    tick();
    tick();
    chk_idle("rst");
    chk("rst_data", tx_data, 4'h0);
    reset = 1'b1;
    tick();
    chk_idle("post_rst");

    // accept 4'hA at edge N
    in_data  = 4'hA;
    in_valid = 1'b1;
    tick();
    chk("acc_req",  tx_req,   1);
    chk("acc_data", tx_data,  4'hA);
    chk("acc_busy", busy,     1);
    chk("acc_rdy",  in_ready, 0);

    // new word offered while in REQ is ignored
    in_data = 4'h5;
    tick();
    chk("req_hold_data", tx_data, 4'hA);
    tick();
    tx_ack = 1'b1;
    tick();
    chk("ack_k_req", tx_req, 1);
    tick();
    chk("ack_k1_req", tx_req, 1);
    tick();
    chk("ack_k2_req",  tx_req,  0);
    chk("ack_k2_busy", busy,    1);
    chk("ack_k2_data", tx_data, 4'hA);
    chk("ack_k2_done", done,    0);
    in_valid = 1'b0;

    // drop ack: done at m+2
    tx_ack = 1'b0;
    tick();
    chk("rel_m_done", done, 0);
    tick();
    chk("rel_m1_done", done, 0);
    chk("rel_m1_busy", busy, 1);
    tick();
    chk("rel_m2_done", done,     1);
    chk("rel_m2_rdy",  in_ready, 1);
    chk("rel_m2_busy", busy,     0);
    chk("rel_m2_data", tx_data,  4'hA);

    // back-to-back accept in the done cycle
    in_data  = 4'h3;
    in_valid = 1'b1;
    tick();
    chk("b2b_req",  tx_req,  1);
    chk("b2b_data", tx_data, 4'h3);
    chk("b2b_done", done,    0);
    in_valid = 1'b0;

    // async reset while in REQ with ack high
    tx_ack = 1'b1;
    tick();
    chk("pre_abort_req", tx_req, 1);
    #2;
    reset = 1'b0;
    #1;
    chk_idle("abort");
    chk("abort_data", tx_data, 4'h0);
    tx_ack = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    tick();
    chk_idle("abort_rel");

    // clean transfer after reset
    in_data  = 4'hC;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t2_req",  tx_req,  1);
    chk("t2_data", tx_data, 4'hC);
    tx_ack = 1'b1;
    tick();
    tick();
    chk("t2_k1_req", tx_req, 1);
    tick();
    chk("t2_k2_req", tx_req, 0);
    tx_ack = 1'b0;
    tick();
    tick();
    chk("t2_m1_done", done, 0);
    tick();
    chk("t2_m2_done", done, 1);
    tick();
    chk("t2_after_done", done, 0);

    // narrow ack pulse in IDLE
    #1;
    tx_ack = 1'b1;
    #2;
    tx_ack = 1'b0;
    tick();
    chk_idle("glitch1");
    tick();
    chk_idle("glitch2");
    tick();
    chk_idle("glitch3");

    // ack held high in IDLE: ignored, then REQ exits at once
    tx_ack = 1'b1;
    tick();
    tick();
    tick();
    chk_idle("viol");
    in_data  = 4'h9;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("viol_req",  tx_req,  1);
    chk("viol_data", tx_data, 4'h9);
    tick();
    chk("viol_req_drop", tx_req, 0);
    chk("viol_busy",     busy,   1);
    tx_ack = 1'b0;
    tick();
    tick();
    chk("viol_m1_done", done, 0);
    tick();
    chk("viol_m2_done", done, 1);
    chk("viol_m2_rdy",  in_ready, 1);
    chk("viol_m2_data", tx_data, 4'h9);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
